// File: rtl/serial_parity_checker.sv
// Serial frame receiver: start bit, DATA_W data bits LSB first, parity bit.
// Define STOP_BIT_EN to require a trailing stop bit (must be 0) per frame.
module serial_parity_checker #(
   parameter int DATA_W    = 8,
   parameter int ODD       = 0,
   parameter int ERR_CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 x,
   input  logic                 x_valid,
   output logic [DATA_W-1:0]    data_out,
   output logic                 done,
   output logic                 parity_err,
   output logic                 framing_err,
   output logic [ERR_CNT_W-1:0] err_count
);

   localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);
   localparam logic OP = (ODD != 0);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2
`ifdef STOP_BIT_EN
      ,STOP  = 2'd3
`endif
   } state_t;

   state_t            state, state_d;
   logic [DATA_W-1:0] sr;
   logic [CW-1:0]     cnt;
   logic              par;
   logic              start, shift, fin;
   logic              err_now, bad;

`ifdef STOP_BIT_EN
   logic err_q, latch_err, ferr_now;
`endif

   always_comb begin
      state_d = state;
      start   = 1'b0;
      shift   = 1'b0;
      fin     = 1'b0;
      err_now = par ^ x ^ OP;
`ifdef STOP_BIT_EN
      latch_err = 1'b0;
      ferr_now  = 1'b0;
`endif
      if (x_valid) begin
         case (state)
            IDLE: begin
               if (x) begin
                  state_d = DATA;
                  start   = 1'b1;
               end
            end
            DATA: begin
               shift = 1'b1;
               if (cnt == LAST) state_d = PARITY;
            end
            PARITY: begin
`ifdef STOP_BIT_EN
               latch_err = 1'b1;
               state_d   = STOP;
`else
               fin     = 1'b1;
               state_d = IDLE;
`endif
            end
`ifdef STOP_BIT_EN
            STOP: begin
               // stop bit must be 0; a 1 is a framing error
               fin      = 1'b1;
               err_now  = err_q;
               ferr_now = x;
               state_d  = IDLE;
            end
`endif
            default: state_d = IDLE;
         endcase
      end
   end

`ifdef STOP_BIT_EN
   assign bad = err_now | ferr_now;
`else
   assign bad = err_now;
   assign framing_err = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         sr         <= '0;
         cnt        <= '0;
         par        <= 1'b0;
         data_out   <= '0;
         done       <= 1'b0;
         parity_err <= 1'b0;
         err_count  <= '0;
      end else begin
         state <= state_d;
         done  <= fin;
         if (start) begin
            sr  <= '0;
            cnt <= '0;
            par <= 1'b0;
         end
         if (shift) begin
            sr  <= {x, sr[DATA_W-1:1]};
            par <= par ^ x;
            if (cnt != LAST) cnt <= cnt + 1'b1;
         end
         if (fin) begin
            data_out   <= sr;
            parity_err <= err_now;
            if (bad && err_count != '1) err_count <= err_count + 1'b1;
         end
      end
   end

`ifdef STOP_BIT_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         err_q       <= 1'b0;
         framing_err <= 1'b0;
      end else begin
         if (latch_err) err_q <= err_now;
         if (fin) framing_err <= ferr_now;
      end
   end
`endif

endmodule

// File: tb/tb_serial_parity_checker.sv
// Directed bench for serial_parity_checker (even and odd parity instances).
// Compile with STOP_BIT_EN defined to exercise the stop-bit checks.
module tb_serial_parity_checker;

   localparam int W = 8;
`ifdef STOP_BIT_EN
   localparam int FL = W + 3;
`else
   localparam int FL = W + 2;
`endif

   logic         clk = 1'b0;
   logic         reset;
   logic         x;
   logic         x_valid;
   logic [W-1:0] data_out, o_data_out;
   logic         done, o_done;
   logic         parity_err, o_parity_err;
   logic         framing_err, o_framing_err;
   logic [7:0]   err_count, o_err_count;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int dn = 0;
   int dc[$];
   logic [W-1:0] dd[$];
   logic dpo[$];

   serial_parity_checker #(.DATA_W(W), .ODD(0), .ERR_CNT_W(8)) u_dut (
      .clk(clk), .reset(reset), .x(x), .x_valid(x_valid),
      .data_out(data_out), .done(done), .parity_err(parity_err),
      .framing_err(framing_err), .err_count(err_count)
   );

   serial_parity_checker #(.DATA_W(W), .ODD(1), .ERR_CNT_W(8)) u_odd (
      .clk(clk), .reset(reset), .x(x), .x_valid(x_valid),
      .data_out(o_data_out), .done(o_done), .parity_err(o_parity_err),
      .framing_err(o_framing_err), .err_count(o_err_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (done) begin
         dn++;
         dc.push_back(cyc);
         dd.push_back(data_out);
         dpo.push_back(o_parity_err);
      end
   end

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic idle(input int n);
      x_valid = 1'b0;
      x = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_bit(input logic b, input int gap);
      idle(gap);
      x = b;
      x_valid = 1'b1;
      @(posedge clk);
      #1;
      x_valid = 1'b0;
      x = 1'b0;
   endtask

   task automatic send_frame(input logic [W-1:0] d, input logic p,
                             input logic s, input int gap);
      send_bit(1'b1, 0);
      for (int i = 0; i < W; i++) send_bit(d[i], gap);
      send_bit(p, gap);
`ifdef STOP_BIT_EN
      send_bit(s, gap);
`endif
   endtask

   task automatic do_reset(input int n);
      reset = 1'b1;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
      reset = 1'b0;
   endtask

   int n0;

   initial begin
      reset = 1'b1;
      x = 1'b0;
      x_valid = 1'b0;
      do_reset(2);

      check("rst_data", data_out, 0);
      check("rst_done", done, 0);
      check("rst_perr", parity_err, 0);
      check("rst_ferr", framing_err, 0);
      check("rst_cnt", err_count, 0);

      // good frame A5, even parity 0
      send_frame(8'hA5, 1'b0, 1'b0, 0);
      check("good_done", done, 1);
      check("good_data", data_out, 8'hA5);
      check("good_perr", parity_err, 0);
      check("good_cnt", err_count, 0);
      check("good_odd_perr", o_parity_err, 1);
      check("good_odd_cnt", o_err_count, 1);
      idle(1);
      check("good_done_1cyc", done, 0);

      // bad parity, then saturation
      send_frame(8'hA5, 1'b1, 1'b0, 0);
      check("bad_perr", parity_err, 1);
      check("bad_cnt", err_count, 1);
      check("bad_ferr", framing_err, 0);
      send_frame(8'hA5, 1'b1, 1'b0, 0);
      check("bad_cnt2", err_count, 2);
      for (int i = 0; i < 298; i++) send_frame(8'hA5, 1'b1, 1'b0, 0);
      check("sat_cnt", err_count, 8'hFF);
      check("sat_perr", parity_err, 1);
      do_reset(2);
      check("rst2_cnt", err_count, 0);
      check("rst2_data", data_out, 0);

      // gapped frame 3C
      n0 = dn;
      send_frame(8'h3C, 1'b0, 1'b0, 3);
      check("gap_done", done, 1);
      check("gap_data", data_out, 8'h3C);
      check("gap_perr", parity_err, 0);
      idle(4);
      check("gap_once", dn - n0, 1);

      // reset mid-frame after 4 data bits
      n0 = dn;
      send_bit(1'b1, 0);
      for (int i = 0; i < 4; i++) send_bit(1'b1, 0);
      do_reset(1);
      idle(W + 4);
      check("mid_nodone", dn - n0, 0);
      check("mid_data", data_out, 0);
      check("mid_perr", parity_err, 0);
      check("mid_cnt", err_count, 0);
      check("mid_ferr", framing_err, 0);
      send_frame(8'h01, 1'b1, 1'b0, 0);
      check("mid_clean_data", data_out, 8'h01);
      check("mid_clean_perr", parity_err, 0);

      // back-to-back A5 then 0F, no gap
      idle(2);
      n0 = dn;
      send_frame(8'hA5, 1'b0, 1'b0, 0);
      send_frame(8'h0F, 1'b0, 1'b0, 0);
      idle(2);
      check("b2b_count", dn - n0, 2);
      if (dn - n0 == 2) begin
         check("b2b_spacing", dc[n0+1] - dc[n0], FL);
         check("b2b_data0", dd[n0], 8'hA5);
         check("b2b_data1", dd[n0+1], 8'h0F);
         check("b2b_odd0", dpo[n0], 1);
         check("b2b_odd1", dpo[n0+1], 1);
      end
      check("b2b_cnt", err_count, 0);
      check("b2b_ferr", framing_err, 0);

`ifdef STOP_BIT_EN
      send_frame(8'hA5, 1'b0, 1'b1, 0);
      check("stop1_ferr", framing_err, 1);
      check("stop1_perr", parity_err, 0);
      check("stop1_cnt", err_count, 1);
      send_frame(8'hA5, 1'b0, 1'b0, 0);
      check("stop0_ferr", framing_err, 0);
      check("stop0_cnt", err_count, 1);
`endif

      idle(2);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
